// File: rtl/ewb_multi.sv
// ewb_multi: DEPTH-entry eviction write buffer; serves read hits, forwards misses, drains oldest-first when idle or full.
// Optional EWB_COALESCE_EN merges a write into a buffered entry with the same address instead of allocating.
module ewb_multi #(
  parameter int DEPTH       = 4,
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = 256,
  parameter int IDLE_CYCLES = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              u_read,
  input  logic              u_write,
  input  logic [ADDR_W-1:0] u_addr,
  input  logic [LINE_W-1:0] u_wdata,
  output logic [LINE_W-1:0] u_rdata,
  output logic              u_resp,
  output logic              l_read,
  output logic              l_write,
  output logic [ADDR_W-1:0] l_addr,
  output logic [LINE_W-1:0] l_wdata,
  input  logic [LINE_W-1:0] l_rdata,
  input  logic              l_resp,
  output logic              empty,
  output logic              full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDL_W = $clog2(IDLE_CYCLES + 1);
`ifdef EWB_COALESCE_EN
  localparam bit COALESCE = 1'b1;
`else
  localparam bit COALESCE = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    HIT_DETECT,
    MEM_READ,
    WRITE_BACK,
    WR_ACK
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DEPTH-1:0]  r_valid;
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [LINE_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic [IDL_W-1:0]  r_idle_cnt;

  logic              w_hit;
  logic [PTR_W-1:0]  w_hit_idx;
  logic              w_alloc;
  logic              w_merge;
  logic              w_pop;
  logic              w_idle_dec;

  assign empty = (r_count == '0);
  assign full  = (r_count == CNT_W'(DEPTH));

  // Scan oldest to youngest so the last match seen is the youngest duplicate.
  always_comb begin
    logic [PTR_W-1:0] v_idx;
    w_hit     = 1'b0;
    w_hit_idx = '0;
    v_idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      v_idx = r_head + PTR_W'(k);
      if (r_valid[v_idx] && (r_addr[v_idx] == u_addr)) begin
        w_hit     = 1'b1;
        w_hit_idx = v_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_alloc     = 1'b0;
    w_merge     = 1'b0;
    w_pop       = 1'b0;
    w_idle_dec  = 1'b0;
    u_resp      = 1'b0;
    u_rdata     = '0;
    l_read      = 1'b0;
    l_write     = 1'b0;
    l_addr      = '0;
    l_wdata     = '0;
    case (r_state)
      IDLE: begin
        if (u_write) begin
          if (COALESCE && w_hit) begin
            w_merge     = 1'b1;
            w_state_nxt = WR_ACK;
          end else if (!full) begin
            w_alloc     = 1'b1;
            w_state_nxt = WR_ACK;
          end else begin
            w_state_nxt = WRITE_BACK;
          end
        end else if (u_read) begin
          w_state_nxt = HIT_DETECT;
        end else if (r_count != '0) begin
          if (r_idle_cnt == '0) w_state_nxt = WRITE_BACK;
          else                  w_idle_dec  = 1'b1;
        end
      end
      HIT_DETECT: begin
        if (w_hit) begin
          u_resp      = 1'b1;
          u_rdata     = r_data[w_hit_idx];
          w_state_nxt = IDLE;
        end else begin
          // Miss is known combinationally, so the lower read starts this cycle.
          l_read = 1'b1;
          l_addr = u_addr;
          if (l_resp) begin
            u_resp      = 1'b1;
            u_rdata     = l_rdata;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = MEM_READ;
          end
        end
      end
      MEM_READ: begin
        l_read = 1'b1;
        l_addr = u_addr;
        if (l_resp) begin
          u_resp      = 1'b1;
          u_rdata     = l_rdata;
          w_state_nxt = IDLE;
        end
      end
      WRITE_BACK: begin
        l_write = 1'b1;
        l_addr  = r_addr[r_head];
        l_wdata = r_data[r_head];
        if (l_resp) begin
          w_pop       = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      WR_ACK: begin
        u_resp      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_valid    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_idle_cnt <= IDL_W'(IDLE_CYCLES);
    end else begin
      r_state <= w_state_nxt;
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_addr[r_tail]  <= u_addr;
        r_data[r_tail]  <= u_wdata;
        r_tail          <= r_tail + PTR_W'(1);
      end
      if (w_merge) r_data[w_hit_idx] <= u_wdata;
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      if (w_alloc)    r_count <= r_count + CNT_W'(1);
      else if (w_pop) r_count <= r_count - CNT_W'(1);
      if (u_read || u_write || w_pop) r_idle_cnt <= IDL_W'(IDLE_CYCLES);
      else if (w_idle_dec)            r_idle_cnt <= r_idle_cnt - IDL_W'(1);
    end
  end
endmodule
